imm_extend_pipe: RTL and testbench
==================================

// Module: imm_extend_pipe
// PURPOSE
//  Parametrised, pipelined immediate generator for the decode stage of the ARM pipeline.
//  Decodes ImmSrc modes for data-processing (rotated imm8), LDR/STR (imm12), LDRH/STRH
//  (split imm8), branch (signed imm24<<2) and MOVW (imm16). Also produces the
//  rotate-immediate shifter carry.
//  Elastic valid/ready pipeline of STAGES registers with flush; sits between fetch/decode
//  and the register-read/execute boundary.
// PARAMETERS
//  XLEN    32  output width; legal values 32 or 64; all extensions are to XLEN
//  STAGES  1   pipeline register count, 1..3; latency in cycles when not stalled
//  ROT_EN  1   1: DP mode applies the 4-bit rotate; 0: DP imm8 is zero-extended, rot ignored
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      synchronous, active-high
//  flush      in   1      synchronous pipeline flush
//  in_valid   in   1      instr/ImmSrc/carry_in are valid this cycle
//  in_ready   out  1      block accepts input this cycle
//  ImmSrc     in   3      mode select, see BEHAVIOUR
//  Instr      in   24     Instr[23:0] of the fetched word
//  carry_in   in   1      current CPSR.C, used for the rotate carry
//  out_valid  out  1      ext_imm/imm_carry/illegal are valid
//  out_ready  in   1      downstream consumes the output this cycle
//  ExtImm     out  XLEN   extended immediate
//  imm_carry  out  1      shifter carry-out for DP rotated immediate
//  illegal    out  1      ImmSrc was a reserved encoding
// BEHAVIOUR
//  Reset: all stage valids=0; out_valid=0, ExtImm=0, imm_carry=0, illegal=0. in_ready=1 one cycle after reset deasserts.
//  Modes (computed in 32 bits, then zero/sign-extended to XLEN as stated):
//   000 DP:   rot=Instr[11:8]; v=ror32({24'b0,Instr[7:0]}, 2*rot), zero-ext;
//             imm_carry = (rot==0) ? carry_in : v[31]
//   001 MEM12: zero-ext Instr[11:0]; imm_carry=carry_in
//   010 BR:   sign-ext {Instr[23:0],2'b00} from bit 25; imm_carry=carry_in
//   011 MEMH: zero-ext {Instr[11:8],Instr[3:0]}; imm_carry=carry_in
//   100 MOVW: zero-ext {Instr[19:16],Instr[11:0]}; imm_carry=carry_in
//   101-111:  ExtImm=0, imm_carry=carry_in, illegal=1 (never X)
//  Pipeline: decode is combinational into stage 0; stage i loads when !v[i] or stage i
//   advances; last stage advances when out_valid & out_ready. in_ready = !v[0] | stage0 advances.
//  Throughput one per cycle; latency exactly STAGES cycles with out_ready held 1.
//  Stall: while out_valid & !out_ready, ExtImm/imm_carry/illegal are held stable.
//   Bubbles collapse: upstream stages keep filling until all STAGES are full.
//  Flush: all valids cleared next edge; an input accepted in the flush cycle is dropped;
//   flush beats load; data regs need not clear. out_valid=0 the cycle after flush.
//  Reset beats flush. Reset mid-stall discards all in-flight entries.
//  Ordering strictly FIFO; no entry is ever duplicated or dropped except by flush/reset.
// STRUCTURE
//  Package imm_pkg: typedef enum logic[2:0] imm_src_e {IMM_DP,IMM_MEM12,IMM_BR,IMM_MEMH,
//   IMM_MOVW}; localparam IMM_SRC_W=3; struct imm_res_t {ext, carry, illegal}.
//  Sub-module imm_decode_comb: pure combinational mode decode (XLEN, ROT_EN), returns imm_res_t.
//  Top holds a generate loop of STAGES valid+imm_res_t registers and the ready chain.
// TESTING
//  DP rotate: Instr=0x0004FF, ImmSrc=000 -> ExtImm=0xFF000000, imm_carry=1;
//   Instr=0x00007F, carry_in=1 -> 0x0000007F, carry 1.
//  BR/XLEN=64: Instr=0xFFFFFE -> 0xFFFF_FFFF_FFFF_FFF8; Instr=0x000001 -> 0x4.
//  MEMH Instr=0x000A05 -> 0xA5; MOVW Instr=0x0A0CDE -> 0xACDE; ImmSrc=110 -> 0, illegal=1.
//  STAGES=2 backpressure: 4 back-to-back inputs, out_ready=0 for 3 cycles ->
//   in_ready drops after 2 are accepted; all 4 are emitted in order; output held during stall.
//  Flush while 2 entries are in flight and in_valid=1 -> out_valid=0 next cycle;
//   the next output is the first input after flush.
//  Reset asserted mid-stall -> out_valid=0, ExtImm=0 next edge; in_ready=1 after release.

Source files
------------

// File: rtl/imm_extend_pipe_pkg.sv
// Shared types for the decode-stage immediate generator: mode encodings,
// the per-entry result record carried down the pipeline, and a rotate helper.
package imm_pkg;

  localparam int unsigned IMM_SRC_W = 3;

  // Widest supported XLEN; the result record is sized for it so that one
  // struct type serves every XLEN (upper bits are constant zero at XLEN=32).
  localparam int unsigned XLEN_MAX = 64;

  typedef enum logic [IMM_SRC_W-1:0] {
    IMM_DP    = 3'b000,
    IMM_MEM12 = 3'b001,
    IMM_BR    = 3'b010,
    IMM_MEMH  = 3'b011,
    IMM_MOVW  = 3'b100
  } imm_src_e;

  typedef struct packed {
    logic [XLEN_MAX-1:0] ext;
    logic                carry;
    logic                illegal;
  } imm_res_t;

  // 32-bit rotate right; a shift by 32 yields zero, so sh==0 returns x.
  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] sh);
    logic [5:0] lsh;
    lsh = 6'd32 - {1'b0, sh};
    return (x >> sh) | (x << lsh);
  endfunction

endpackage

// File: rtl/imm_extend_pipe_decode.sv
// Pure combinational ImmSrc decode: builds the XLEN-wide immediate, the
// rotate-immediate shifter carry and the reserved-encoding flag.
module imm_decode_comb
  import imm_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter bit          ROT_EN = 1'b1
) (
  input  logic [IMM_SRC_W-1:0] imm_src_i,
  input  logic [23:0]          instr_i,
  input  logic                 carry_i,
  output imm_res_t             res_o
);

  logic [31:0]     rot_v;
  logic [25:0]     br_v;
  logic [XLEN-1:0] ext;
  logic            carry;
  logic            illegal;

  // Mode decode; every path defaults to ext=0, carry passthrough, legal.
  always_comb begin
    ext     = '0;
    carry   = carry_i;
    illegal = 1'b0;
    rot_v   = ror32({24'b0, instr_i[7:0]}, {instr_i[11:8], 1'b0});
    br_v    = {instr_i, 2'b00};

    case (imm_src_e'(imm_src_i))
      IMM_DP: begin
        if (ROT_EN) begin
          ext = XLEN'(rot_v);
          if (instr_i[11:8] != 4'd0) begin
            carry = rot_v[31];
          end
        end else begin
          ext = XLEN'(instr_i[7:0]);
        end
      end
      IMM_MEM12: ext = XLEN'(instr_i[11:0]);
      IMM_BR:    ext = {{(XLEN-26){br_v[25]}}, br_v};
      IMM_MEMH:  ext = XLEN'({instr_i[11:8], instr_i[3:0]});
      IMM_MOVW:  ext = XLEN'({instr_i[19:16], instr_i[11:0]});
      default:   illegal = 1'b1;
    endcase
  end

  // Pack into the shared record, zero-filling above XLEN.
  always_comb begin
    res_o         = '0;
    res_o.ext     = XLEN_MAX'(ext);
    res_o.carry   = carry;
    res_o.illegal = illegal;
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate generator: combinational decode feeding an elastic
// valid/ready chain of STAGES registers with synchronous flush.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 1,
  parameter bit          ROT_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IMM_SRC_W-1:0] ImmSrc,
  input  logic [23:0]          Instr,
  input  logic                 carry_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      ExtImm,
  output logic                 imm_carry,
  output logic                 illegal
);

  imm_res_t          dec_res;
  logic [STAGES-1:0] stage_valid;
  imm_res_t          stage_data [STAGES];
  // ready[i]: stage i may load this cycle; ready[STAGES] is the consumer.
  logic [STAGES:0]   ready;

  imm_decode_comb #(
    .XLEN   (XLEN),
    .ROT_EN (ROT_EN)
  ) u_decode (
    .imm_src_i (ImmSrc),
    .instr_i   (Instr),
    .carry_i   (carry_in),
    .res_o     (dec_res)
  );

  // Ready chain from the output back: an empty stage always accepts, so
  // bubbles collapse while the consumer is stalled.
  always_comb begin
    ready = '0;
    ready[STAGES] = out_ready;
    for (int unsigned k = 0; k < STAGES; k++) begin
      ready[STAGES-1-k] = !stage_valid[STAGES-1-k] | ready[STAGES-k];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic     up_valid;
    imm_res_t up_data;
    logic     valid_q, valid_d;
    imm_res_t data_q, data_d;

    if (g == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = dec_res;
    end else begin : g_body
      assign up_valid = stage_valid[g-1];
      assign up_data  = stage_data[g-1];
    end

    // Next state: flush beats load; data only moves with a valid entry so
    // a stalled or drained stage keeps presenting its last value.
    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (ready[g]) begin
        valid_d = up_valid;
        if (up_valid) begin
          data_d = up_data;
        end
      end
      if (flush) begin
        valid_d = 1'b0;
      end
    end

    // Stage register; reset clears data too so outputs read zero.
    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

    assign stage_valid[g] = valid_q;
    assign stage_data[g]  = data_q;
  end

  assign in_ready  = ready[0];
  assign out_valid = stage_valid[STAGES-1];
  assign ExtImm    = stage_data[STAGES-1].ext[XLEN-1:0];
  assign imm_carry = stage_data[STAGES-1].carry;
  assign illegal   = stage_data[STAGES-1].illegal;

  if (XLEN < XLEN_MAX) begin : g_narrow
    logic unused_ext_hi;
    assign unused_ext_hi = ^stage_data[STAGES-1].ext[XLEN_MAX-1:XLEN];
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe (XLEN=64, STAGES=2): vector table
// streamed through a scoreboard, plus stall, flush and reset sequences.
module tb_imm_extend_pipe;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned STAGES = 2;

  logic            clk;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      ImmSrc;
  logic [23:0]     Instr;
  logic            carry_in;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] ExtImm;
  logic            imm_carry;
  logic            illegal;

  imm_extend_pipe #(
    .XLEN   (XLEN),
    .STAGES (STAGES),
    .ROT_EN (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ImmSrc    (ImmSrc),
    .Instr     (Instr),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ExtImm    (ExtImm),
    .imm_carry (imm_carry),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  src;
    logic [23:0] instr;
    logic        cin;
    logic [63:0] ext;
    logic        carry;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [63:0] ext;
    logic        carry;
    logic        ill;
  } exp_t;

  vec_t vecs [17];
  exp_t sbq [$];
  exp_t cur_exp;
  int   checks;
  int   failures;
  logic accepted;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    ImmSrc   = v.src;
    Instr    = v.instr;
    carry_in = v.cin;
    cur_exp  = '{v.ext, v.carry, v.ill};
  endtask

  // One clock: observe output and handshake mid-cycle, then advance to the
  // next falling edge where the caller updates inputs.
  task automatic cycle();
    #1;
    accepted = 1'b0;
    if (out_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got ExtImm=0x%0h with nothing outstanding", ExtImm);
      end else begin
        chk("ext", ExtImm, sbq[0].ext);
        chk("carry", {63'b0, imm_carry}, {63'b0, sbq[0].carry});
        chk("illegal", {63'b0, illegal}, {63'b0, sbq[0].ill});
        if (out_ready && !flush && !reset) void'(sbq.pop_front());
      end
    end
    if (in_valid && in_ready && !reset) begin
      accepted = 1'b1;
      if (!flush) sbq.push_back(cur_exp);
    end
    if (flush || reset) sbq.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input vec_t v);
    drive(v);
    for (int n = 0; n < 20; n++) begin
      cycle();
      if (accepted) break;
    end
    if (!accepted) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=%0b expected 1 within 20 cycles", in_ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 40 && sbq.size() > 0; n++) cycle();
    chk("drain_empty", 64'(sbq.size()), 64'd0);
    cycle();
    chk("drain_idle", {63'b0, out_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ImmSrc    = '0;
    Instr     = '0;
    carry_in  = 1'b0;
    accepted  = 1'b0;
    cur_exp   = '{64'd0, 1'b0, 1'b0};

    vecs[0]  = '{3'b000, 24'h0004FF, 1'b0, 64'h0000_0000_FF00_0000, 1'b1, 1'b0};
    vecs[1]  = '{3'b000, 24'h00007F, 1'b1, 64'h0000_0000_0000_007F, 1'b1, 1'b0};
    vecs[2]  = '{3'b000, 24'h00007F, 1'b0, 64'h0000_0000_0000_007F, 1'b0, 1'b0};
    vecs[3]  = '{3'b000, 24'h000102, 1'b0, 64'h0000_0000_8000_0000, 1'b1, 1'b0};
    vecs[4]  = '{3'b000, 24'h000F01, 1'b1, 64'h0000_0000_0000_0004, 1'b0, 1'b0};
    vecs[5]  = '{3'b001, 24'h123ABC, 1'b1, 64'h0000_0000_0000_0ABC, 1'b1, 1'b0};
    vecs[6]  = '{3'b010, 24'hFFFFFE, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0};
    vecs[7]  = '{3'b010, 24'h000001, 1'b1, 64'h0000_0000_0000_0004, 1'b1, 1'b0};
    vecs[8]  = '{3'b010, 24'h7FFFFF, 1'b0, 64'h0000_0000_01FF_FFFC, 1'b0, 1'b0};
    vecs[9]  = '{3'b010, 24'h800000, 1'b1, 64'hFFFF_FFFF_FE00_0000, 1'b1, 1'b0};
    vecs[10] = '{3'b011, 24'h000A05, 1'b0, 64'h0000_0000_0000_00A5, 1'b0, 1'b0};
    vecs[11] = '{3'b011, 24'hFFFFFF, 1'b1, 64'h0000_0000_0000_00FF, 1'b1, 1'b0};
    vecs[12] = '{3'b100, 24'h0A0CDE, 1'b1, 64'h0000_0000_0000_ACDE, 1'b1, 1'b0};
    vecs[13] = '{3'b100, 24'hFFFFFF, 1'b0, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0};
    vecs[14] = '{3'b110, 24'h123456, 1'b1, 64'h0000_0000_0000_0000, 1'b1, 1'b1};
    vecs[15] = '{3'b101, 24'hFFFFFF, 1'b0, 64'h0000_0000_0000_0000, 1'b0, 1'b1};
    vecs[16] = '{3'b111, 24'h0004FF, 1'b1, 64'h0000_0000_0000_0000, 1'b1, 1'b1};

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_ext", ExtImm, 64'd0);
    chk("rst_carry", {63'b0, imm_carry}, 64'd0);
    chk("rst_illegal", {63'b0, illegal}, 64'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);

    // Latency: exactly STAGES cycles with out_ready held high.
    drive(vecs[0]);
    cycle();
    in_valid = 1'b0;
    #1;
    chk("lat_edge1", {63'b0, out_valid}, 64'd0);
    cycle();
    #1;
    chk("lat_edge2", {63'b0, out_valid}, 64'd1);
    drain();

    // Table streamed back to back.
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i]);
      cycle();
      chk("stream_accept", {63'b0, accepted}, 64'd1);
    end
    drain();

    // Backpressure: 3 stall cycles, 4 inputs back to back.
    out_ready = 1'b0;
    drive(vecs[7]);
    cycle();
    chk("bp_acc0", {63'b0, accepted}, 64'd1);
    drive(vecs[10]);
    cycle();
    chk("bp_acc1", {63'b0, accepted}, 64'd1);
    drive(vecs[12]);
    #1;
    chk("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
    cycle();
    chk("bp_acc2_blocked", {63'b0, accepted}, 64'd0);
    out_ready = 1'b1;
    cycle();
    chk("bp_acc2", {63'b0, accepted}, 64'd1);
    drive(vecs[14]);
    cycle();
    chk("bp_acc3", {63'b0, accepted}, 64'd1);
    drain();

    // Flush with two entries in flight and in_valid high.
    out_ready = 1'b0;
    drive(vecs[5]);
    cycle();
    drive(vecs[6]);
    cycle();
    drive(vecs[9]);
    flush = 1'b1;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_out_valid", {63'b0, out_valid}, 64'd0);
    out_ready = 1'b1;
    send(vecs[13]);
    drain();

    // Flush in the same cycle an input is handshaken: that input is dropped.
    out_ready = 1'b0;
    drive(vecs[3]);
    cycle();
    drive(vecs[4]);
    flush = 1'b1;
    #1;
    chk("flush2_in_ready", {63'b0, in_ready}, 64'd1);
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("flush2_out_valid", {63'b0, out_valid}, 64'd0);
    cycle();
    cycle();
    chk("flush2_dropped", {63'b0, out_valid}, 64'd0);
    send(vecs[11]);
    drain();

    // Reset while stalled discards everything in flight.
    out_ready = 1'b0;
    drive(vecs[0]);
    cycle();
    drive(vecs[16]);
    cycle();
    in_valid = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    #1;
    chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("midrst_ext", ExtImm, 64'd0);
    chk("midrst_carry", {63'b0, imm_carry}, 64'd0);
    chk("midrst_illegal", {63'b0, illegal}, 64'd0);
    reset = 1'b0;
    cycle();
    #1;
    chk("midrst_in_ready", {63'b0, in_ready}, 64'd1);
    out_ready = 1'b1;
    send(vecs[8]);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
